rover_nav_sequencer: RTL and testbench
======================================

Name: rover_nav_sequencer

Overview:
Clocked navigation controller for the line-following rover. It conditions the active-low inductive line sensors and the proximity and red-marker inputs, then runs a state machine that sequences the two-motor drive through line following, junction branch turns, and 180° cone-recovery spins. It drives the same motor direction/enable bus the motor H-bridges consume and replaces the ad-hoc combinational/edge-triggered decision logic with a single synchronous sequencer.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required before a synchronized input is accepted
TURN_MIN_CYCLES, 50000, minimum cycles a junction turn or spin is held before a re-acquire may end it
TURN_TIMEOUT, 2000000, cycles in any turn/spin state before declaring fault
CNT_W, 22, width of the turn counter; must hold TURN_TIMEOUT

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
induct  input  3  line sensors {left,middle,right}, active low (0 = on tape)
proxim  input  1  cone detected, active high
red  input  1  red junction marker, active high
motor_in  output  4  motor direction code
motor_en  output  2  motor enables, 11 = both on
branch_sel  output  1  current junction decision: 0 = right, 1 = left
cone_flag  output  1  cone seen since last red falling edge
state  output  3  current FSM state encoding (debug)
fault  output  1  sticky turn-timeout fault

Behaviour:
- Codes: FWD=0110, LEFT=1010, RIGHT=0101, STOP=0000. BR(branch_sel)=RIGHT if 0, LEFT if 1.
- Conditioning: induct, proxim, red each pass a 2-FF synchronizer, then a per-signal filter: the filtered value takes the synchronized value once it has been equal for DEBOUNCE_CYCLES consecutive cycles. red edges are detected on the filtered value.
- All outputs registered. Latency from a raw input change held stable to the motor output change = 3 + DEBOUNCE_CYCLES cycles.
- Reset: motor_in=0000, motor_en=00, branch_sel=0, cone_flag=0, fault=0, state=STARTUP, counters=0.
- States (encoding): STARTUP=0, FOLLOW=1, JUNCTION=2, SPIN_OFF=3, SPIN_SEEK=4, FAULT=5.
- STARTUP: motors STOP/en=00 for DEBOUNCE_CYCLES+2 cycles, then FOLLOW.
- FOLLOW (en=11): 101→FWD; 001/011→LEFT; 100/110→RIGHT; 010/111→hold last code; 000→JUNCTION (counter cleared).
- JUNCTION (en=11, motor_in=BR): exits to FOLLOW when induct==101 and counter>=TURN_MIN_CYCLES.
- SPIN_OFF (en=11, motor_in=BR): goes to SPIN_SEEK when induct==111 and counter>=TURN_MIN_CYCLES. SPIN_SEEK keeps the same code; goes to FOLLOW on induct==101. The counter is not cleared between SPIN_OFF and SPIN_SEEK.
- Cone: filtered proxim rising while in FOLLOW or JUNCTION sets cone_flag=1 and enters SPIN_OFF with the counter cleared. proxim is ignored in spin states.
- red rising edge: toggles branch_sel in any non-FAULT state. If cone_flag=1 at that edge and state is FOLLOW/JUNCTION, enter SPIN_OFF. The new branch_sel drives the spin from the next cycle.
- red falling edge: clears cone_flag.
- Simultaneous red-rise and proxim-rise in the same cycle: branch_sel toggles, cone_flag=1, enter SPIN_OFF.
- Counter saturates. Counter reaching TURN_TIMEOUT in JUNCTION/SPIN_OFF/SPIN_SEEK → FAULT.
- FAULT: motor_in=STOP, motor_en=00, fault=1. Left only by reset.
- Reset asserted mid-turn returns all outputs to reset values immediately (asynchronous), then STARTUP.

Test Plan:
(Bench params: DEBOUNCE_CYCLES=4, TURN_MIN_CYCLES=8, TURN_TIMEOUT=64.)
- Reset release with induct=101 → en=00 for 6 cycles; FOLLOW then motor_in=0110, en=11 exactly 7 cycles after an induct change.
- induct 101→011 held → motor_in=1010. Then 111 → motor_in stays 1010. Then 2-cycle glitch to 100 → no change (filtered).
- induct=000 with branch_sel=0 → JUNCTION, motor_in=0101. induct=101 after 3 cycles → stays JUNCTION until counter=8, then FOLLOW with 0110.
- proxim pulse held 6 cycles in FOLLOW → cone_flag=1, SPIN_OFF with 0101. induct 111 (after ≥8) → SPIN_SEEK, then 101 → FOLLOW. red rise → branch_sel=1 and SPIN_OFF with 1010. red fall → cone_flag=0.
- JUNCTION with induct stuck at 000 → fault=1, motor_en=00, motor_in=0000 at counter=64. Input changes afterwards → no exit. rst_n low → all outputs cleared.
- red and proxim rise in the same cycle in FOLLOW → branch_sel toggles, cone_flag=1, state=3.

Source files
------------

// File: rtl/rover_nav_sequencer.sv
// rtl/rover_nav_sequencer.sv - line-following rover navigation sequencer
// Sensor conditioning (2-FF sync + debounce) feeding one registered drive FSM.

module rover_nav_debounce #(
   parameter int             W               = 1,
   parameter int             DEBOUNCE_CYCLES = 4,
   parameter logic [W-1:0]   RST_VAL         = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_raw,
   output logic [W-1:0] o_filt
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] L_DB = CW'(DEBOUNCE_CYCLES);

   logic [W-1:0]  r_sync1;
   logic [W-1:0]  r_sync2;
   logic [W-1:0]  r_last;
   logic [W-1:0]  r_filt;
   logic [CW-1:0] r_run;
   logic [CW-1:0] w_run;

   // w_run counts consecutive identical synchronized samples, including this one
   always_comb begin
      w_run = CW'(1);
      if (r_sync2 == r_last)
         w_run = (r_run >= L_DB) ? L_DB : r_run + CW'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= RST_VAL;
         r_sync2 <= RST_VAL;
         r_last  <= RST_VAL;
         r_filt  <= RST_VAL;
         r_run   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_last  <= r_sync2;
         r_run   <= w_run;
         if (w_run >= L_DB)
            r_filt <= r_sync2;
      end
   end

   assign o_filt = r_filt;
endmodule

module rover_nav_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TURN_MIN_CYCLES = 50000,
   parameter int TURN_TIMEOUT    = 2000000,
   parameter int CNT_W           = 22
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [2:0] i_induct,
   input  logic       i_proxim,
   input  logic       i_red,
   output logic [3:0] o_motor_in,
   output logic [1:0] o_motor_en,
   output logic       o_branch_sel,
   output logic       o_cone_flag,
   output logic [2:0] o_state,
   output logic       o_fault
);
   typedef enum logic [2:0] {
      ST_STARTUP   = 3'd0,
      ST_FOLLOW    = 3'd1,
      ST_JUNCTION  = 3'd2,
      ST_SPIN_OFF  = 3'd3,
      ST_SPIN_SEEK = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   localparam logic [3:0] C_FWD   = 4'b0110;
   localparam logic [3:0] C_LEFT  = 4'b1010;
   localparam logic [3:0] C_RIGHT = 4'b0101;
   localparam logic [3:0] C_STOP  = 4'b0000;

   localparam logic [CNT_W-1:0] L_START   = CNT_W'(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] L_MIN     = CNT_W'(TURN_MIN_CYCLES);
   localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TURN_TIMEOUT);
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

   logic [2:0]       w_induct_f;
   logic             w_prox_f;
   logic             w_red_f;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_motor_in;
   logic [1:0]       r_motor_en;
   logic             r_branch;
   logic             r_cone;
   logic             r_fault;
   logic             r_red_q;
   logic             r_prox_q;

   logic             w_red_rise;
   logic             w_red_fall;
   logic             w_prox_rise;
   logic             w_br_next;
   logic [3:0]       w_br_code;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_timeout;
   logic             w_fj;
   logic             w_start_spin;

   rover_nav_debounce #(.W(3), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(3'b111)) u_db_induct (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_induct), .o_filt(w_induct_f));
   rover_nav_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_proxim (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_proxim), .o_filt(w_prox_f));
   rover_nav_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_red (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_red), .o_filt(w_red_f));

   assign w_red_rise   = w_red_f & ~r_red_q;
   assign w_red_fall   = ~w_red_f & r_red_q;
   assign w_prox_rise  = w_prox_f & ~r_prox_q;
   // Turns use the branch value after this cycle's red toggle
   assign w_br_next    = r_branch ^ w_red_rise;
   assign w_br_code    = w_br_next ? C_LEFT : C_RIGHT;
   assign w_cnt_inc    = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_timeout    = (w_cnt_inc >= L_TIMEOUT);
   assign w_fj         = (r_state == ST_FOLLOW) || (r_state == ST_JUNCTION);
   assign w_start_spin = w_fj && (w_prox_rise || (w_red_rise && r_cone));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_STARTUP;
         r_cnt      <= '0;
         r_motor_in <= C_STOP;
         r_motor_en <= 2'b00;
         r_branch   <= 1'b0;
         r_cone     <= 1'b0;
         r_fault    <= 1'b0;
         r_red_q    <= 1'b0;
         r_prox_q   <= 1'b0;
      end else begin
         r_red_q  <= w_red_f;
         r_prox_q <= w_prox_f;
         if (r_state != ST_FAULT) begin
            r_branch <= w_br_next;
            if (w_fj && w_prox_rise)
               r_cone <= 1'b1;
            else if (w_red_fall)
               r_cone <= 1'b0;
         end
         case (r_state)
            ST_STARTUP: begin
               r_motor_in <= C_STOP;
               r_motor_en <= 2'b00;
               r_cnt      <= w_cnt_inc;
               if (r_cnt >= L_START) begin
                  r_state    <= ST_FOLLOW;
                  r_motor_en <= 2'b11;
                  r_cnt      <= '0;
               end
            end
            ST_FOLLOW: begin
               r_motor_en <= 2'b11;
               if (w_start_spin) begin
                  r_state    <= ST_SPIN_OFF;
                  r_cnt      <= '0;
                  r_motor_in <= w_br_code;
               end else begin
                  case (w_induct_f)
                     3'b101:         r_motor_in <= C_FWD;
                     3'b001, 3'b011: r_motor_in <= C_LEFT;
                     3'b100, 3'b110: r_motor_in <= C_RIGHT;
                     3'b000: begin
                        r_state    <= ST_JUNCTION;
                        r_cnt      <= '0;
                        r_motor_in <= w_br_code;
                     end
                     default:        r_motor_in <= r_motor_in;
                  endcase
               end
            end
            ST_JUNCTION, ST_SPIN_OFF, ST_SPIN_SEEK: begin
               r_motor_en <= 2'b11;
               r_motor_in <= w_br_code;
               r_cnt      <= w_cnt_inc;
               if (w_timeout) begin
                  r_state    <= ST_FAULT;
                  r_motor_in <= C_STOP;
                  r_motor_en <= 2'b00;
                  r_fault    <= 1'b1;
               end else if (w_start_spin) begin
                  r_state <= ST_SPIN_OFF;
                  r_cnt   <= '0;
               end else if (r_state == ST_JUNCTION) begin
                  if (w_induct_f == 3'b101 && r_cnt >= L_MIN) begin
                     r_state    <= ST_FOLLOW;
                     r_motor_in <= C_FWD;
                  end
               end else if (r_state == ST_SPIN_OFF) begin
                  if (w_induct_f == 3'b111 && r_cnt >= L_MIN)
                     r_state <= ST_SPIN_SEEK;
               end else if (w_induct_f == 3'b101) begin
                  r_state    <= ST_FOLLOW;
                  r_motor_in <= C_FWD;
               end
            end
            default: begin
               r_state    <= ST_FAULT;
               r_motor_in <= C_STOP;
               r_motor_en <= 2'b00;
               r_fault    <= 1'b1;
            end
         endcase
      end
   end

   assign o_motor_in   = r_motor_in;
   assign o_motor_en   = r_motor_en;
   assign o_branch_sel = r_branch;
   assign o_cone_flag  = r_cone;
   assign o_state      = r_state;
   assign o_fault      = r_fault;
endmodule

// File: tb/tb_rover_nav_sequencer.sv
// tb/tb_rover_nav_sequencer.sv - directed checks of the rover navigation sequencer

module tb_rover_nav_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] induct;
   logic       proxim;
   logic       red;
   logic [3:0] motor_in;
   logic [1:0] motor_en;
   logic       branch_sel;
   logic       cone_flag;
   logic [2:0] state;
   logic       fault;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [2:0] induct;
      logic [3:0] motor;
   } vec_t;
   vec_t tbl [10];

   rover_nav_sequencer #(
      .DEBOUNCE_CYCLES(4), .TURN_MIN_CYCLES(8), .TURN_TIMEOUT(64), .CNT_W(8)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_induct(induct), .i_proxim(proxim), .i_red(red),
      .o_motor_in(motor_in), .o_motor_en(motor_en), .o_branch_sel(branch_sel),
      .o_cone_flag(cone_flag), .o_state(state), .o_fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [3:0] prev_m;
      int k;

      tbl[0] = '{3'b101, 4'b0110};
      tbl[1] = '{3'b011, 4'b1010};
      tbl[2] = '{3'b111, 4'b1010};
      tbl[3] = '{3'b100, 4'b0101};
      tbl[4] = '{3'b010, 4'b0101};
      tbl[5] = '{3'b110, 4'b0101};
      tbl[6] = '{3'b001, 4'b1010};
      tbl[7] = '{3'b101, 4'b0110};
      tbl[8] = '{3'b011, 4'b1010};
      tbl[9] = '{3'b111, 4'b1010};

      rst_n = 1'b0; induct = 3'b101; proxim = 1'b0; red = 1'b0;
      step(3);
      chk("rst_motor_in", 32'(motor_in), 32'h0);
      chk("rst_motor_en", 32'(motor_en), 32'h0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("startup_en", 32'(motor_en), 32'h0);
      end
      step(1);
      chk("startup_exit_en", 32'(motor_en), 32'h3);
      chk("startup_exit_state", 32'(state), 32'd1);
      step(1);
      chk("startup_fwd", 32'(motor_in), 32'h6);

      prev_m = 4'b0110;
      for (int i = 0; i < 10; i++) begin
         induct = tbl[i].induct;
         step(6);
         chk("follow_latency", 32'(motor_in), 32'(prev_m));
         step(1);
         chk("follow_code", 32'(motor_in), 32'(tbl[i].motor));
         prev_m = tbl[i].motor;
      end

      induct = 3'b100;
      step(2);
      induct = 3'b111;
      step(12);
      chk("glitch_motor", 32'(motor_in), 32'ha);
      chk("glitch_state", 32'(state), 32'd1);

      induct = 3'b101;
      step(7);
      chk("pre_junction_fwd", 32'(motor_in), 32'h6);
      induct = 3'b000;
      step(4);
      induct = 3'b101;
      step(3);
      chk("junction_state", 32'(state), 32'd2);
      chk("junction_motor", 32'(motor_in), 32'h5);
      step(5);
      chk("junction_min_hold", 32'(state), 32'd2);
      step(3);
      chk("junction_min_hold2", 32'(state), 32'd2);
      step(1);
      chk("junction_exit_state", 32'(state), 32'd1);
      chk("junction_exit_motor", 32'(motor_in), 32'h6);

      proxim = 1'b1;
      step(6);
      chk("cone_latency", 32'(cone_flag), 32'd0);
      step(1);
      chk("cone_flag_set", 32'(cone_flag), 32'd1);
      chk("cone_spin_state", 32'(state), 32'd3);
      chk("cone_spin_motor", 32'(motor_in), 32'h5);
      proxim = 1'b0;
      induct = 3'b111;
      step(8);
      chk("spin_off_min_hold", 32'(state), 32'd3);
      step(1);
      chk("spin_seek_state", 32'(state), 32'd4);
      chk("spin_seek_motor", 32'(motor_in), 32'h5);
      induct = 3'b101;
      step(7);
      chk("spin_reacquire_state", 32'(state), 32'd1);
      chk("spin_reacquire_motor", 32'(motor_in), 32'h6);

      red = 1'b1;
      step(6);
      chk("red_latency", 32'(branch_sel), 32'd0);
      step(1);
      chk("red_branch_toggle", 32'(branch_sel), 32'd1);
      chk("red_cone_spin_state", 32'(state), 32'd3);
      chk("red_cone_spin_motor", 32'(motor_in), 32'ha);
      red = 1'b0;
      step(6);
      chk("red_fall_latency", 32'(cone_flag), 32'd1);
      step(1);
      chk("red_fall_clear", 32'(cone_flag), 32'd0);
      chk("red_fall_branch", 32'(branch_sel), 32'd1);
      induct = 3'b111;
      step(7);
      chk("spin2_seek", 32'(state), 32'd4);
      induct = 3'b101;
      step(7);
      chk("spin2_follow", 32'(state), 32'd1);

      red = 1'b1; proxim = 1'b1;
      step(7);
      chk("simul_branch", 32'(branch_sel), 32'd0);
      chk("simul_cone", 32'(cone_flag), 32'd1);
      chk("simul_state", 32'(state), 32'd3);
      chk("simul_motor", 32'(motor_in), 32'h5);
      red = 1'b0; proxim = 1'b0;
      step(7);
      chk("simul_cone_clear", 32'(cone_flag), 32'd0);
      induct = 3'b111;
      step(7);
      induct = 3'b101;
      step(7);
      chk("simul_back_follow", 32'(state), 32'd1);

      induct = 3'b000;
      step(7);
      chk("stuck_junction", 32'(state), 32'd2);
      k = 0;
      while (!fault && k < 100) begin
         step(1);
         k++;
      end
      chk("timeout_cycles", 32'(k), 32'd64);
      chk("fault_flag", 32'(fault), 32'd1);
      chk("fault_en", 32'(motor_en), 32'h0);
      chk("fault_motor", 32'(motor_in), 32'h0);
      chk("fault_state", 32'(state), 32'd5);
      induct = 3'b101; red = 1'b1; proxim = 1'b1;
      step(12);
      chk("fault_sticky_state", 32'(state), 32'd5);
      chk("fault_sticky_flag", 32'(fault), 32'd1);
      chk("fault_branch_frozen", 32'(branch_sel), 32'd0);

      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_fault", 32'(fault), 32'd0);
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_en", 32'(motor_en), 32'h0);
      chk("async_rst_motor", 32'(motor_in), 32'h0);
      chk("async_rst_branch", 32'(branch_sel), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
